// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle main controller for the MIPS core.
//
// Sequences a shared ALU, register file and single-port memory through
// fetch / decode / execute / memory / write-back states.  Only the state
// register is clocked; every datapath select and strobe is decoded
// combinationally from the current state, the latched instruction fields
// (opcode/func from IR) and the memory acknowledge.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset (forces IDLE)
//   opcode[5:0]  in   instruction bits [31:26] from IR
//   func[5:0]    in   instruction bits [5:0] from IR
//   zero         in   ALU zero flag (branch decision is taken in the datapath)
//   mem_ack      in   memory completed the current access this cycle
//   mem_req      out  memory request, held until mem_ack
//   MemRead      out  1 = read, 0 = write
//   IorD         out  address select: 0 = PC, 1 = ALUOut
//   IRWrite      out  load IR
//   PCWrite      out  unconditional PC load
//   PCWriteCond  out  PC load qualified by zero
//   PCSource     out  00 ALU, 01 ALUOut, 10 jump target, 11 register A
//   ALUSrcA      out  0 = PC, 1 = register A
//   ALUSrcB      out  00 B, 01 const 4, 10 ext imm, 11 ext imm << 2
//   ExtOp        out  1 = sign-extend immediate, 0 = zero-extend
//   ALUop_ctr    out  4-bit ALU operation code
//   Shift        out  ALU A operand is shamt
//   RegDst       out  0 = rt, 1 = rd
//   MemtoReg     out  0 = ALUOut, 1 = MDR
//   RegWrite     out  register-file write
//   instr_done   out  pulse on the last cycle of an instruction
//   illegal      out  pulse on an unsupported encoding (in DECODE)
//   state[3:0]   out  current state, for debug
// -----------------------------------------------------------------------------
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       MemRead,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [3:0] ALUop_ctr,
    output logic       Shift,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b1110;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_JR   = 4'b1100;

    // ALU code for an R-type func; unsupported encodings give 0000, never x.
    function automatic logic [3:0] func_alu_code(input logic [5:0] f);
        logic [3:0] code;
        case (f)
            FN_ADD:  code = ALU_ADD;
            FN_SUB:  code = ALU_SUB;
            FN_AND:  code = ALU_AND;
            FN_OR:   code = ALU_OR;
            FN_XOR:  code = ALU_XOR;
            FN_SLL:  code = ALU_SLL;
            FN_SRL:  code = ALU_SRL;
            FN_SRA:  code = ALU_SRA;
            FN_JR:   code = ALU_JR;
            default: code = ALU_NONE;
        endcase
        return code;
    endfunction

    // Every supported func maps to a non-zero ALU code, so legality falls out of the table.
    function automatic logic func_supported(input logic [5:0] f);
        return (func_alu_code(f) != ALU_NONE);
    endfunction

    function automatic logic func_is_shift(input logic [5:0] f);
        return (f == FN_SLL) || (f == FN_SRL) || (f == FN_SRA);
    endfunction

    state_t state_q;
    state_t state_d;

    // The branch decision is made in the datapath (PCWriteCond & zero), not here.
    logic unused_zero_s;
    assign unused_zero_s = zero;

    assign state = state_q;

    // State register; reset aborts any instruction immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state output decode.
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        MemRead     = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ExtOp       = 1'b0;
        ALUop_ctr   = ALU_NONE;
        Shift       = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        instr_done  = 1'b0;
        illegal     = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                // PC + 4 is computed every fetch cycle but only committed with the IR load.
                mem_req   = 1'b1;
                MemRead   = 1'b1;
                ALUSrcB   = 2'b01;
                ALUop_ctr = ALU_ADD;
                if (mem_ack) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_DECODE: begin
                // Branch target PC + (imm << 2) is computed speculatively into ALUOut.
                ALUSrcB   = 2'b11;
                ExtOp     = 1'b1;
                ALUop_ctr = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_BEQ:          state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_ADDI, OP_ORI: state_d = S_IEXEC;
                    OP_RTYPE: begin
                        if (func_supported(func)) begin
                            state_d = S_EXEC;
                        end else begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ExtOp     = 1'b1;
                ALUop_ctr = ALU_ADD;
                if (opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_MEMRD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ack) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end

            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEMWR: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (mem_ack) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_MEMWR;
                end
            end

            S_EXEC: begin
                ALUSrcA   = 1'b1;
                ALUop_ctr = func_alu_code(func);
                Shift     = func_is_shift(func);
                if (func == FN_JR) begin
                    PCSource   = 2'b11;
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_RWB;
                end
            end

            S_RWB: begin
                // Shared by R-type (writes rd) and immediate ops (write rt).
                RegWrite   = 1'b1;
                RegDst     = (opcode == OP_RTYPE);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop_ctr   = ALU_SUB;
                PCSource    = 2'b01;
                PCWriteCond = 1'b1;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end

            S_JUMP: begin
                PCSource   = 2'b10;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OP_ORI) begin
                    ExtOp     = 1'b0;
                    ALUop_ctr = ALU_OR;
                end else begin
                    ExtOp     = 1'b1;
                    ALUop_ctr = ALU_ADD;
                end
                state_d = S_RWB;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl -- self-checking bench for mc_ctrl.
// Each instruction is expanded into a list of expected per-cycle outcomes
// (state plus every control output) from the instruction-level rules, then
// replayed against the DUT cycle by cycle.  Latency to instr_done is also
// checked against the per-instruction cycle counts.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       mem_ack;
    logic       mem_req, MemRead, IorD, IRWrite, PCWrite, PCWriteCond;
    logic [1:0] PCSource;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtOp;
    logic [3:0] ALUop_ctr;
    logic       Shift, RegDst, MemtoReg, RegWrite, instr_done, illegal;
    logic [3:0] state;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .MemRead(MemRead), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp),
        .ALUop_ctr(ALUop_ctr), .Shift(Shift), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       MemRead;
        logic       IorD;
        logic       IRWrite;
        logic       PCWrite;
        logic       PCWriteCond;
        logic [1:0] PCSource;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic       ExtOp;
        logic [3:0] ALUop_ctr;
        logic       Shift;
        logic       RegDst;
        logic       MemtoReg;
        logic       RegWrite;
        logic       instr_done;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic [3:0] st;
        logic       ack;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        outs_t      o;
    } step_t;

    outs_t got;
    assign got = {mem_req, MemRead, IorD, IRWrite, PCWrite, PCWriteCond, PCSource,
                  ALUSrcA, ALUSrcB, ExtOp, ALUop_ctr, Shift, RegDst, MemtoReg,
                  RegWrite, instr_done, illegal};

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                           S_MEMADR = 4'd3, S_MEMRD = 4'd4, S_MEMWB = 4'd5,
                           S_MEMWR = 4'd6, S_EXEC = 4'd7, S_RWB = 4'd8,
                           S_BRANCH = 4'd9, S_JUMP = 4'd10, S_IEXEC = 4'd11;

    localparam int K_R = 0, K_JR = 1, K_LW = 2, K_SW = 3, K_BEQ = 4,
                   K_J = 5, K_ADDI = 6, K_ORI = 7, K_ILL = 8;

    step_t plan[$];
    int    vectors     = 0;
    int    miscompares = 0;

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        logic [3:0] c;
        case (fn)
            6'b100000: c = 4'b1110;
            6'b100010: c = 4'b0100;
            6'b100100: c = 4'b0010;
            6'b100101: c = 4'b0011;
            6'b100110: c = 4'b0111;
            6'b000000: c = 4'b1010;
            6'b000010: c = 4'b1000;
            6'b000011: c = 4'b1001;
            6'b001000: c = 4'b1100;
            default:   c = 4'b0000;
        endcase
        return c;
    endfunction

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        int k;
        case (op)
            6'b000000: begin
                if (fn == 6'b001000)            k = K_JR;
                else if (alu_of(fn) != 4'b0000) k = K_R;
                else                            k = K_ILL;
            end
            6'b100011: k = K_LW;
            6'b101011: k = K_SW;
            6'b000100: k = K_BEQ;
            6'b000010: k = K_J;
            6'b001000: k = K_ADDI;
            6'b001101: k = K_ORI;
            default:   k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic outs_t fetch_o(input logic ack);
        outs_t o;
        o = '0;
        o.mem_req   = 1'b1;
        o.MemRead   = 1'b1;
        o.ALUSrcB   = 2'b01;
        o.ALUop_ctr = 4'b1110;
        o.IRWrite   = ack;
        o.PCWrite   = ack;
        return o;
    endfunction

    task automatic add_step(input logic [3:0] st, input logic ack, input logic [5:0] op,
                            input logic [5:0] fn, input logic z, input outs_t o);
        step_t s;
        s.st = st; s.ack = ack; s.op = op; s.fn = fn; s.z = z; s.o = o;
        plan.push_back(s);
    endtask

    // Expand one instruction into expected cycles. fw/mw = fetch/memory wait cycles.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw,
                         input int mw, input logic zb, output int lat);
        outs_t o;
        int    k;
        k = kind_of(op, fn);
        for (int i = 0; i < fw; i++)
            add_step(S_FETCH, 1'b0, 6'($urandom), 6'($urandom), 1'($urandom), fetch_o(1'b0));
        add_step(S_FETCH, 1'b1, 6'($urandom), 6'($urandom), 1'($urandom), fetch_o(1'b1));
        o = '0; o.ALUSrcB = 2'b11; o.ExtOp = 1'b1; o.ALUop_ctr = 4'b1110;
        o.illegal = (k == K_ILL);
        add_step(S_DECODE, 1'($urandom), op, fn, 1'($urandom), o);
        lat = -1;
        case (k)
            K_R: begin
                o = '0; o.ALUSrcA = 1'b1; o.ALUop_ctr = alu_of(fn);
                o.Shift = (fn == 6'b000000) || (fn == 6'b000010) || (fn == 6'b000011);
                add_step(S_EXEC, 1'($urandom), op, fn, 1'($urandom), o);
                o = '0; o.RegWrite = 1'b1; o.RegDst = 1'b1; o.instr_done = 1'b1;
                add_step(S_RWB, 1'($urandom), op, fn, 1'($urandom), o);
                lat = 4 + fw;
            end
            K_JR: begin
                o = '0; o.ALUSrcA = 1'b1; o.ALUop_ctr = 4'b1100; o.PCSource = 2'b11;
                o.PCWrite = 1'b1; o.instr_done = 1'b1;
                add_step(S_EXEC, 1'($urandom), op, fn, 1'($urandom), o);
                lat = 3 + fw;
            end
            K_LW, K_SW: begin
                o = '0; o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10; o.ExtOp = 1'b1; o.ALUop_ctr = 4'b1110;
                add_step(S_MEMADR, 1'($urandom), op, fn, 1'($urandom), o);
                for (int i = 0; i <= mw; i++) begin
                    o = '0; o.mem_req = 1'b1; o.IorD = 1'b1;
                    o.MemRead = (k == K_LW);
                    o.instr_done = (k == K_SW) && (i == mw);
                    add_step((k == K_LW) ? S_MEMRD : S_MEMWR, (i == mw), op, fn, 1'($urandom), o);
                end
                if (k == K_LW) begin
                    o = '0; o.RegWrite = 1'b1; o.MemtoReg = 1'b1; o.instr_done = 1'b1;
                    add_step(S_MEMWB, 1'($urandom), op, fn, 1'($urandom), o);
                    lat = 5 + fw + mw;
                end else begin
                    lat = 4 + fw + mw;
                end
            end
            K_BEQ: begin
                o = '0; o.ALUSrcA = 1'b1; o.ALUop_ctr = 4'b0100; o.PCSource = 2'b01;
                o.PCWriteCond = 1'b1; o.instr_done = 1'b1;
                add_step(S_BRANCH, 1'($urandom), op, fn, zb, o);
                lat = 3 + fw;
            end
            K_J: begin
                o = '0; o.PCSource = 2'b10; o.PCWrite = 1'b1; o.instr_done = 1'b1;
                add_step(S_JUMP, 1'($urandom), op, fn, 1'($urandom), o);
                lat = 3 + fw;
            end
            K_ADDI, K_ORI: begin
                o = '0; o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10;
                o.ExtOp = (k == K_ADDI);
                o.ALUop_ctr = (k == K_ADDI) ? 4'b1110 : 4'b0011;
                add_step(S_IEXEC, 1'($urandom), op, fn, 1'($urandom), o);
                o = '0; o.RegWrite = 1'b1; o.instr_done = 1'b1;
                add_step(S_RWB, 1'($urandom), op, fn, 1'($urandom), o);
                lat = 4 + fw;
            end
            default: lat = -1;
        endcase
    endtask

    task automatic check_outs(input string tag, input logic [3:0] exp_st, input outs_t exp_o);
        vectors++;
        assert (state === exp_st) else begin
            miscompares++;
            $error("FAIL %s state: got %0d expected %0d", tag, state, exp_st);
        end
        vectors++;
        assert (got === exp_o) else begin
            miscompares++;
            $error("FAIL %s outputs: got %06h expected %06h", tag, got, exp_o);
        end
    endtask

    // Replay up to max_steps expected cycles; inputs change on negedge, check 2 ns later.
    task automatic run_plan(input string tag, input int exp_lat, input int max_steps);
        step_t s;
        int    cyc;
        int    done_at;
        cyc = 0;
        done_at = -1;
        while (plan.size() > 0 && cyc < max_steps) begin
            s = plan.pop_front();
            @(negedge clk);
            mem_ack = s.ack; opcode = s.op; func = s.fn; zero = s.z;
            #2;
            cyc++;
            check_outs($sformatf("%s.c%0d", tag, cyc), s.st, s.o);
            if (instr_done === 1'b1 && done_at < 0) done_at = cyc;
        end
        plan.delete();
        vectors++;
        assert (done_at == exp_lat) else begin
            miscompares++;
            $error("FAIL %s latency: got %0d expected %0d", tag, done_at, exp_lat);
        end
    endtask

    task automatic instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input int fw, input int mw, input logic zb);
        int lat;
        build(op, fn, fw, mw, zb, lat);
        run_plan(tag, lat, 1000);
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b0;
        #2;
        check_outs(tag, S_IDLE, '0);
    endtask

    logic [5:0] op_tab [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                               6'b000010, 6'b001000, 6'b001101};
    logic [5:0] fn_tab [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                               6'b000000, 6'b000010, 6'b000011, 6'b001000};

    initial begin
        int         lat;
        logic [5:0] rop;
        logic [5:0] rfn;
        int         idx;

        rst = 1'b1; opcode = 6'b000000; func = 6'b000000; zero = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        mem_ack = 1'b1;
        #1;
        check_outs("reset_hold", S_IDLE, '0);
        release_reset("post_reset_idle");

        // directed instructions, memory always acknowledging at once
        instr("add", 6'b000000, 6'b100000, 0, 0, 1'b0);
        instr("sll", 6'b000000, 6'b000000, 0, 0, 1'b0);
        instr("jr", 6'b000000, 6'b001000, 0, 0, 1'b0);
        instr("lw_wait3", 6'b100011, 6'b010101, 0, 3, 1'b0);
        instr("beq_z1", 6'b000100, 6'b000000, 0, 0, 1'b1);
        instr("beq_z0", 6'b000100, 6'b000000, 0, 0, 1'b0);
        instr("ill_op", 6'b111111, 6'b100000, 0, 0, 1'b0);
        instr("ill_fn", 6'b000000, 6'b101010, 0, 0, 1'b0);
        instr("after_ill", 6'b000000, 6'b100010, 0, 0, 1'b0);
        instr("sw_wait2", 6'b101011, 6'b000000, 1, 2, 1'b0);
        instr("j", 6'b000010, 6'b111111, 2, 0, 1'b0);
        instr("addi", 6'b001000, 6'b000000, 0, 0, 1'b0);
        instr("ori", 6'b001101, 6'b000000, 1, 0, 1'b0);
        instr("srl", 6'b000000, 6'b000010, 0, 0, 1'b0);
        instr("sra", 6'b000000, 6'b000011, 0, 0, 1'b0);
        instr("xor", 6'b000000, 6'b100110, 0, 0, 1'b0);

        // reset asserted while waiting in MEMRD
        build(6'b100011, 6'b000000, 0, 6, 1'b0, lat);
        run_plan("lw_pre_rst", -1, 4);
        #1;
        rst = 1'b1;
        mem_ack = 1'b1;
        #1;
        check_outs("rst_async", S_IDLE, '0);
        @(negedge clk);
        #1;
        check_outs("rst_across_edge", S_IDLE, '0);
        release_reset("rst_release_idle");
        instr("add_after_rst", 6'b000000, 6'b100000, 0, 0, 1'b0);

        // randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            idx = $urandom_range(0, 8);
            rop = (idx < 7) ? op_tab[idx] : 6'($urandom);
            idx = $urandom_range(0, 10);
            rfn = (idx < 9) ? fn_tab[idx] : 6'($urandom);
            instr("rand", rop, rfn, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
